// File: rtl/toom_pw_pkg.sv
// Shared constants, index-width helper and the pipeline sideband stage type for the
// time-multiplexed Toom pointwise product stage.
package toom_pw_pkg;

    localparam int unsigned TOOM8_NUM_PTS = 15;
    localparam int unsigned TOOM8_IN_W    = 155;
    // Upper bound on the point-index width carried in the sideband struct.
    localparam int unsigned PW_IDX_MAX_W  = 16;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                    valid;
        logic [PW_IDX_MAX_W-1:0] idx;
        logic                    last;
    } pw_stage_t;

endpackage

// File: rtl/toom_pointwise_seq_if.sv
// Operand/product handshake bundle for toom_pointwise_seq. TOOM_PW_PERF_EN adds the
// stall_cnt/frame_cnt performance counters.
interface toom_pointwise_seq_if
    import toom_pw_pkg::*;
#(
    parameter int unsigned IN_W  = TOOM8_IN_W,
    parameter int unsigned IDX_W = idx_width(TOOM8_NUM_PTS)
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [IN_W-1:0]   in_a;
    logic signed [IN_W-1:0]   in_b;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [2*IN_W-1:0] out_p;
    logic [IDX_W-1:0]         out_idx;
    logic                     out_last;
    logic                     frame_err;
    logic                     err_clr;
`ifdef TOOM_PW_PERF_EN
    logic [31:0]              stall_cnt;
    logic [31:0]              frame_cnt;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready, err_clr,
        input  in_ready, out_valid, out_p, out_idx, out_last, frame_err, stall_cnt, frame_cnt
    );
    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready, err_clr,
        output in_ready, out_valid, out_p, out_idx, out_last, frame_err, stall_cnt, frame_cnt
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_last, out_ready, err_clr,
        input  in_ready, out_valid, out_p, out_idx, out_last, frame_err
    );
    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready, err_clr,
        output in_ready, out_valid, out_p, out_idx, out_last, frame_err
    );
`endif
endinterface

// File: rtl/toom_pw_mul_pipe.sv
// Pipelined full-precision signed IN_W x IN_W multiplier; all PIPE_STAGES registers
// advance together while en_i is high and hold otherwise.
module toom_pw_mul_pipe #(
    parameter int unsigned IN_W        = 155,
    parameter int unsigned PIPE_STAGES = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic signed [IN_W-1:0]   a_i,
    input  logic signed [IN_W-1:0]   b_i,
    output logic signed [2*IN_W-1:0] p_o
);
    localparam int unsigned PW = 2 * IN_W;

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] stage_q [PIPE_STAGES];

    always_comb begin
        a_ext = {{IN_W{a_i[IN_W-1]}}, a_i};
        b_ext = {{IN_W{b_i[IN_W-1]}}, b_i};
        prod  = a_ext * b_ext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_STAGES; i++) stage_q[i] <= '0;
        end else if (en_i) begin
            stage_q[0] <= prod;
            for (int i = 1; i < PIPE_STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign p_o = stage_q[PIPE_STAGES-1];

endmodule

// File: rtl/toom_pointwise_seq.sv
// Serial Toom pointwise product stage: one shared pipelined multiplier, index tagging
// and framing check. Define TOOM_PW_PERF_EN to add stall/frame performance counters.
module toom_pointwise_seq
    import toom_pw_pkg::*;
#(
    parameter int unsigned NUM_PTS     = TOOM8_NUM_PTS,
    parameter int unsigned IN_W        = TOOM8_IN_W,
    parameter int unsigned PIPE_STAGES = 3,
    parameter int unsigned IDX_W       = idx_width(NUM_PTS)
) (
    input logic                 clk,
    input logic                 rst,
    toom_pointwise_seq_if.slave bus
);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_PTS - 1);

    logic             stall;
    logic             accept;
    logic             at_last;
    logic             frame_set;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             frame_err_q, frame_err_d;
    pw_stage_t        side_q [PIPE_STAGES];
    pw_stage_t        side_in;
    pw_stage_t        side_out;
    logic             unused_idx_hi;

    assign side_out = side_q[PIPE_STAGES-1];
    assign stall    = side_out.valid && !bus.out_ready;
    assign accept   = bus.in_valid && !stall;
    assign at_last  = (idx_q == LastIdx);

    always_comb begin
        // Either an early in_last or a missing one at the final point is a framing fault.
        frame_set = accept && (bus.in_last != at_last);
        idx_d     = idx_q;
        if (accept) idx_d = (bus.in_last || at_last) ? '0 : idx_q + IDX_W'(1);
        frame_err_d = frame_err_q;
        if (frame_set) frame_err_d = 1'b1;
        else if (bus.err_clr) frame_err_d = 1'b0;
        side_in.valid = accept;
        side_in.idx   = PW_IDX_MAX_W'(idx_q);
        side_in.last  = at_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < PIPE_STAGES; i++) side_q[i] <= '0;
        end else begin
            idx_q       <= idx_d;
            frame_err_q <= frame_err_d;
            if (!stall) begin
                side_q[0] <= side_in;
                for (int i = 1; i < PIPE_STAGES; i++) side_q[i] <= side_q[i-1];
            end
        end
    end

    toom_pw_mul_pipe #(
        .IN_W       (IN_W),
        .PIPE_STAGES(PIPE_STAGES)
    ) u_mul (
        .clk (clk),
        .rst (rst),
        .en_i(!stall),
        .a_i (bus.in_a),
        .b_i (bus.in_b),
        .p_o (bus.out_p)
    );

    assign bus.in_ready  = !stall;
    assign bus.out_valid = side_out.valid;
    assign bus.out_idx   = side_out.idx[IDX_W-1:0];
    assign bus.out_last  = side_out.last;
    assign bus.frame_err = frame_err_q;
    assign unused_idx_hi = ^side_out.idx;

`ifdef TOOM_PW_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (bus.err_clr) begin
            stall_cnt_d = '0;
            frame_cnt_d = '0;
        end else begin
            if (stall) stall_cnt_d = stall_cnt_q + 32'd1;
            if (side_out.valid && bus.out_ready && side_out.last) frame_cnt_d = frame_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            frame_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_toom_pointwise_seq.sv
// Randomised self-checking bench for toom_pointwise_seq against a queue-based product
// model, with literal expectations for nominal, extreme, framing and reset scenarios.
module tb_toom_pointwise_seq;
    import toom_pw_pkg::*;

    localparam int unsigned NUM_PTS = 15;
    localparam int unsigned IN_W    = 155;
    localparam int unsigned PS      = 3;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned PW      = 2 * IN_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   stall_total = 0;

    always #5 clk = ~clk;

    toom_pointwise_seq_if #(.IN_W(IN_W), .IDX_W(IDX_W)) bus ();

    toom_pointwise_seq #(
        .NUM_PTS    (NUM_PTS),
        .IN_W       (IN_W),
        .PIPE_STAGES(PS),
        .IDX_W      (IDX_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic signed [PW-1:0] p;
        int                   idx;
        logic                 last;
        int                   pcyc;
        int                   pstall;
        bit                   seen;
    } exp_t;

    exp_t                 q[$];
    logic signed [PW-1:0] log_p[$];
    int                   log_idx[$];
    logic                 log_last[$];
    int                   m_cnt = 0;
    logic                 m_err = 1'b0;
    int                   m_stall = 0;
    int                   m_frame = 0;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: each accepted beat's product, its position in the frame, and framing errors.
    always @(negedge clk) begin
        exp_t                 e;
        logic                 stall_now;
        logic                 set;
        logic signed [PW-1:0] ea, eb;
        cyc++;
        if (rst) begin
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_frame_err", bus.frame_err, 0);
            q.delete();
            m_cnt = 0;
            m_err = 1'b0;
            m_stall = 0;
            m_frame = 0;
        end else begin
            stall_now = bus.out_valid && !bus.out_ready;
            chk("in_ready", bus.in_ready, !stall_now);
            chk("frame_err", bus.frame_err, m_err);
`ifdef TOOM_PW_PERF_EN
            chk("stall_cnt", bus.stall_cnt, m_stall);
            chk("frame_cnt", bus.frame_cnt, m_frame);
`endif
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_out: got valid beat idx %0d, expected none", bus.out_idx);
                end else begin
                    chk("out_p", bus.out_p, q[0].p);
                    chk("out_idx", bus.out_idx, q[0].idx);
                    chk("out_last", bus.out_last, q[0].last);
                    if (!q[0].seen) begin
                        chk("latency", cyc - q[0].pcyc, PS + stall_total - q[0].pstall);
                        q[0].seen = 1'b1;
                    end
                    if (bus.out_ready) begin
                        log_p.push_back(bus.out_p);
                        log_idx.push_back(int'(bus.out_idx));
                        log_last.push_back(bus.out_last);
                        void'(q.pop_front());
                    end
                end
            end
            if (bus.err_clr) begin
                m_stall = 0;
                m_frame = 0;
            end else begin
                if (stall_now) m_stall++;
                if (bus.out_valid && bus.out_ready && bus.out_last) m_frame++;
            end
            if (stall_now) stall_total++;
            set = 1'b0;
            if (bus.in_valid && bus.in_ready) begin
                ea = bus.in_a;
                eb = bus.in_b;
                e.p = ea * eb;
                e.idx = m_cnt;
                e.last = (m_cnt == NUM_PTS - 1);
                e.pcyc = cyc;
                e.pstall = stall_total;
                e.seen = 1'b0;
                q.push_back(e);
                set = (bus.in_last != (m_cnt == NUM_PTS - 1));
                m_cnt = (bus.in_last || m_cnt == NUM_PTS - 1) ? 0 : m_cnt + 1;
            end
            m_err = set ? 1'b1 : (bus.err_clr ? 1'b0 : m_err);
        end
    end

    function automatic logic signed [IN_W-1:0] rnd();
        logic [159:0] r;
        for (int k = 0; k < 5; k++) r[k*32 +: 32] = $urandom;
        return r[IN_W-1:0];
    endfunction

    task automatic send(input logic signed [IN_W-1:0] a, input logic signed [IN_W-1:0] b,
                        input logic last, input logic clr);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_a = a;
        bus.in_b = b;
        bus.in_last = last;
        bus.err_clr = clr;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            guard++;
            if (guard > 1000) begin
                $display("FAIL send_timeout: got in_ready stuck low, expected acceptance");
                $fatal(1, "send timeout");
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    task automatic frame(input int n, input int last_at);
        for (int i = 0; i < n; i++) send(rnd(), rnd(), i == last_at, 1'b0);
    endtask

    task automatic drain();
        int g = 0;
        while (q.size() != 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d beats outstanding, expected 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
    endtask

    task automatic clear_log();
        log_p.delete();
        log_idx.delete();
        log_last.delete();
    endtask

    task automatic chk_neg(input string name, input logic act_sel, input logic exp);
        @(negedge clk);
        chk(name, act_sel ? bus.frame_err : bus.out_valid, exp);
        @(posedge clk);
        #1;
    endtask

    logic signed [PW-1:0]   e1, e2;
    logic signed [IN_W-1:0] mn, mx;
    bit                     bp_run;
    logic                   pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b1;
        bus.err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_out_p", bus.out_p, 0);
        chk("reset_out_idx", bus.out_idx, 0);
        chk("reset_out_last", bus.out_last, 0);
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_frame_err", bus.frame_err, 0);
        @(posedge clk);
        #1;

        // Nominal frame
        clear_log();
        for (int i = 0; i < 15; i++) send(i + 1, -(2 * i + 3), i == 14, 1'b0);
        drain();
        chk("nom_count", log_p.size(), 15);
        chk("nom_p0", log_p[0], -310'sd3);
        chk("nom_p14", log_p[14], -310'sd465);
        chk("nom_idx14", log_idx[14], 14);
        chk("nom_last13", log_last[13], 0);
        chk("nom_last14", log_last[14], 1);

        // Extremes
        clear_log();
        mn = '0;
        mn[IN_W-1] = 1'b1;
        mx = ~mn;
        e1 = '0;
        e1[308] = 1'b1;
        e2 = '0;
        for (int k = 154; k < 308; k++) e2[k] = 1'b1;
        e2 = -e2;
        send(mn, mn, 1'b0, 1'b0);
        send(mx, mn, 1'b0, 1'b0);
        frame(13, 12);
        drain();
        chk("ext_min_sq", log_p[0], e1);
        chk("ext_max_min", log_p[1], e2);

        // Backpressure with out_ready 1,0,0,1
        clear_log();
        bp_run = 1'b1;
        fork
            begin
                frame(15, 14);
                drain();
                bp_run = 1'b0;
            end
            begin
                int ph = 0;
                while (bp_run) begin
                    bus.out_ready = pat[ph];
                    ph = (ph + 1) % 4;
                    @(posedge clk);
                    #1;
                end
            end
        join
        bus.out_ready = 1'b1;
        chk("bp_count", log_idx.size(), 15);
        for (int k = 0; k < 15; k++) chk("bp_order", log_idx[k], k);

        // Framing: early in_last on beat 5, then a clean frame
        clear_log();
        frame(6, 5);
        drain();
        chk_neg("early_last_err", 1'b1, 1'b1);
        frame(15, 14);
        drain();
        chk("resync_idx5", log_idx[5], 5);
        chk("resync_idx0", log_idx[6], 0);
        chk("early_last_outlast", log_last[5], 0);
        pulse_clr();
        chk_neg("clr_err", 1'b1, 1'b0);
        frame(15, -1);
        drain();
        chk_neg("missing_last_err", 1'b1, 1'b1);
        pulse_clr();
        chk_neg("clr_err2", 1'b1, 1'b0);
        frame(3, -1);
        send(rnd(), rnd(), 1'b1, 1'b1);
        drain();
        chk_neg("set_beats_clr", 1'b1, 1'b1);
        pulse_clr();

        // Reset mid-frame with beats in flight
        frame(7, -1);
        rst = 1'b1;
        #1;
        chk("rst_async_valid", bus.out_valid, 0);
        chk("rst_async_p", bus.out_p, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        clear_log();
        frame(15, 14);
        drain();
        chk("post_rst_count", log_idx.size(), 15);
        chk("post_rst_idx0", log_idx[0], 0);

`ifdef TOOM_PW_PERF_EN
        pulse_clr();
        fork
            frame(30, 14 + 15 * 0 - 0 > 0 ? 14 : 14);
            begin
                forever begin
                    @(posedge clk);
                    #1;
                    if (bus.out_valid) break;
                end
                bus.out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        @(negedge clk);
        chk("perf_stall", bus.stall_cnt, 4);
        chk("perf_frame", bus.frame_cnt, 2);
        @(posedge clk);
        #1;
        pulse_clr();
        @(negedge clk);
        chk("perf_stall_clr", bus.stall_cnt, 0);
        chk("perf_frame_clr", bus.frame_cnt, 0);
        @(posedge clk);
        #1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
